// File: rtl/gpu_main_controller.sv
// Top-level sequencing FSM of the 2D GPU: configuration first, then instruction
// dispatch to the line+fill engines or the alpha engine. Moore outputs, one-hot enables.
module gpu_main_controller (
   input  logic clk,
   input  logic n_rst,
   input  logic inst_type,
   input  logic alpha_done,
   input  logic fifo_empty,
   input  logic bla_done,
   input  logic config_in,
   input  logic config_done,
   input  logic fill_done,
   output logic read_en,
   output logic alpha_en,
   output logic bla_en,
   output logic config_en,
   output logic fill_en
);

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      CONFIG      = 4'd1,
      WAIT_CONFIG = 4'd2,
      DECODE      = 4'd3,
      BLA         = 4'd4,
      WAIT_BLA    = 4'd5,
      FILL        = 4'd6,
      WAIT_FILL   = 4'd7,
      ALPHA       = 4'd8,
      WAIT_ALPHA  = 4'd9
   } state_e;

   state_e state_q, state_d;

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values; the async reset takes effect without waiting for clk.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Each done/request input is looked at only in the state that owns it, so a
   // stale or held flag is harmlessly absorbed by the following WAIT state.
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latches).
      state_d   = state_q;
      read_en   = 1'b0;
      alpha_en  = 1'b0;
      bla_en    = 1'b0;
      config_en = 1'b0;
      fill_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (config_in) state_d = CONFIG;
         end
         CONFIG: begin
            config_en = 1'b1;
            if (config_done) state_d = WAIT_CONFIG;
         end
         WAIT_CONFIG: begin
            state_d = fifo_empty ? IDLE : DECODE;
         end
         DECODE: begin
            read_en = 1'b1;
            state_d = inst_type ? ALPHA : BLA;
         end
         BLA: begin
            bla_en = 1'b1;
            if (bla_done) state_d = WAIT_BLA;
         end
         WAIT_BLA: begin
            state_d = FILL;
         end
         FILL: begin
            fill_en = 1'b1;
            if (fill_done) state_d = WAIT_FILL;
         end
         WAIT_FILL: begin
            state_d = fifo_empty ? IDLE : DECODE;
         end
         ALPHA: begin
            alpha_en = 1'b1;
            if (alpha_done) state_d = WAIT_ALPHA;
         end
         WAIT_ALPHA: begin
            state_d = fifo_empty ? IDLE : DECODE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gpu_main_controller.sv
// Directed bench for gpu_main_controller: walks config, line, alpha, back-to-back,
// stray-done and async-reset scenarios; outputs are checked as one 5-bit vector.
module tb_gpu_main_controller;

   logic clk = 1'b0;
   logic n_rst;
   logic inst_type, alpha_done, fifo_empty, bla_done, config_in, config_done, fill_done;
   logic read_en, alpha_en, bla_en, config_en, fill_en;
   logic [4:0] outs;

   int tests = 0;
   int fails = 0;

   // Vector order: {read_en, alpha_en, bla_en, config_en, fill_en}
   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] RD   = 5'b10000;
   localparam logic [4:0] ALP  = 5'b01000;
   localparam logic [4:0] BL   = 5'b00100;
   localparam logic [4:0] CFG  = 5'b00010;
   localparam logic [4:0] FIL  = 5'b00001;

   always #5 clk = ~clk;

   gpu_main_controller dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .inst_type   (inst_type),
      .alpha_done  (alpha_done),
      .fifo_empty  (fifo_empty),
      .bla_done    (bla_done),
      .config_in   (config_in),
      .config_done (config_done),
      .fill_done   (fill_done),
      .read_en     (read_en),
      .alpha_en    (alpha_en),
      .bla_en      (bla_en),
      .config_en   (config_en),
      .fill_en     (fill_en)
   );

   assign outs = {read_en, alpha_en, bla_en, config_en, fill_en};

   task automatic check(input string tag, input logic [4:0] exp);
      tests++;
      assert (outs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, outs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // At most one enable in any cycle, sampled away from the active edge.
   always @(negedge clk) begin
      tests++;
      assert ($onehot0(outs)) else begin
         fails++;
         $error("FAIL onehot: observed %b expected at most one bit set", outs);
      end
   end

   initial begin
      n_rst = 1'b0; inst_type = 1'b0; alpha_done = 1'b0; fifo_empty = 1'b1;
      bla_done = 1'b0; config_in = 1'b0; config_done = 1'b0; fill_done = 1'b0;
      #3;
      check("reset_outputs", NONE);
      tick();
      n_rst = 1'b1;
      fifo_empty = 1'b0;
      tick(); check("idle_ignores_fifo", NONE);
      tick(); check("idle_ignores_fifo2", NONE);

      // Stray done flags in IDLE
      bla_done = 1'b1; fill_done = 1'b1; alpha_done = 1'b1;
      tick(); check("idle_stray_done", NONE);
      bla_done = 1'b0; fill_done = 1'b0; alpha_done = 1'b0;

      // Config path, config_done held low for 3 cycles with stray dones
      config_in = 1'b1;
      tick(); check("config_enter", CFG);
      config_in = 1'b0;
      bla_done = 1'b1; fill_done = 1'b1; alpha_done = 1'b1;
      tick(); check("config_hold1", CFG);
      tick(); check("config_hold2", CFG);
      bla_done = 1'b0; fill_done = 1'b0; alpha_done = 1'b0;
      tick(); check("config_hold3", CFG);
      config_done = 1'b1; fifo_empty = 1'b1;
      tick(); check("wait_config", NONE);
      config_done = 1'b0;
      tick(); check("config_to_idle", NONE);
      fifo_empty = 1'b0;
      tick(); check("idle_after_config", NONE);

      // Config then line instruction
      config_in = 1'b1;
      tick(); check("config_enter2", CFG);
      config_in = 1'b0; config_done = 1'b1;
      tick(); check("wait_config2", NONE);
      config_done = 1'b0; inst_type = 1'b0;
      tick(); check("decode_line", RD);
      tick(); check("bla_enter", BL);
      tick(); check("bla_hold", BL);
      bla_done = 1'b1;
      tick(); check("wait_bla", NONE);
      tick(); check("fill_enter_stale_bla_done", FIL);
      bla_done = 1'b0;
      tick(); check("fill_hold", FIL);
      fill_done = 1'b1;
      tick(); check("wait_fill", NONE);
      inst_type = 1'b1;
      tick(); check("decode_held_fill_done", RD);
      tick(); check("alpha_enter", ALP);
      fill_done = 1'b0;
      tick(); check("alpha_hold2", ALP);
      tick(); check("alpha_hold3", ALP);
      alpha_done = 1'b1; fifo_empty = 1'b1;
      tick(); check("wait_alpha", NONE);
      alpha_done = 1'b0;
      tick(); check("alpha_to_idle", NONE);
      tick(); check("idle_stays", NONE);

      // Back-to-back line then alpha, dones high on first active cycle
      fifo_empty = 1'b0; config_in = 1'b1;
      tick(); check("b2b_config", CFG);
      config_in = 1'b0; config_done = 1'b1;
      tick(); check("b2b_wait_config", NONE);
      config_done = 1'b0; inst_type = 1'b0; bla_done = 1'b1;
      tick(); check("b2b_decode1", RD);
      tick(); check("b2b_bla_one_cycle", BL);
      tick(); check("b2b_wait_bla", NONE);
      bla_done = 1'b0; fill_done = 1'b1;
      tick(); check("b2b_fill_one_cycle", FIL);
      tick(); check("b2b_wait_fill", NONE);
      fill_done = 1'b0; inst_type = 1'b1; alpha_done = 1'b1;
      tick(); check("b2b_decode2", RD);
      tick(); check("b2b_alpha_one_cycle", ALP);
      tick(); check("b2b_wait_alpha", NONE);
      alpha_done = 1'b0; inst_type = 1'b0;
      tick(); check("b2b_decode3", RD);
      tick(); check("b2b_bla_again", BL);

      // Async reset mid-clock while in BLA
      #2;
      n_rst = 1'b0;
      #1;
      check("async_reset_in_bla", NONE);
      tick(); check("reset_held", NONE);
      n_rst = 1'b1; fifo_empty = 1'b0; config_in = 1'b0;
      tick(); check("post_reset_idle1", NONE);
      tick(); check("post_reset_idle2", NONE);
      config_in = 1'b1;
      tick(); check("post_reset_config", CFG);
      config_in = 1'b0;

      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gpu_main_controller.md
Name: gpu_main_controller

Overview:
Top-level sequencing FSM of the 2D GPU. It waits for a configuration request, runs the configuration block, then pops instructions from the instruction FIFO one at a time and dispatches each to an engine: a line instruction goes to the Bresenham line engine followed by the fill engine, and an alpha instruction goes to the alpha-blend engine. It sits between the instruction FIFO/decoder and the drawing engines, issuing one-hot enables and consuming their done flags.

Parameters:
None. The state encoding is internal; 4-bit binary is sufficient for the 10 states.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- n_rst  input  1  reset; asynchronous, active-low
- inst_type  input  1  decoded instruction type, valid during DECODE; 0 = line (BLA), 1 = alpha
- alpha_done  input  1  alpha engine finished
- fifo_empty  input  1  instruction FIFO empty
- bla_done  input  1  line engine finished
- config_in  input  1  request to start configuration
- config_done  input  1  configuration block finished
- fill_done  input  1  fill engine finished
- read_en  output  1  pop/decode one instruction from the FIFO
- alpha_en  output  1  enable alpha engine
- bla_en  output  1  enable line engine
- config_en  output  1  enable configuration block
- fill_en  output  1  enable fill engine

Behaviour:
- Moore FSM: outputs are decoded from the state register only. At most one output is high in any cycle.
- Reset: n_rst=0 forces state IDLE immediately, independent of clk. All outputs are 0 while in reset.
- Reset asserted mid-operation aborts the current operation; there is no resume.

States, outputs and transitions (evaluated at each rising edge):
- IDLE: all outputs 0. config_in=1 -> CONFIG; otherwise stay. fifo_empty is ignored in IDLE.
- CONFIG: config_en=1. config_done=1 -> WAIT_CONFIG; otherwise stay.
- WAIT_CONFIG: all outputs 0; single cycle. fifo_empty=0 -> DECODE, else -> IDLE.
- DECODE: read_en=1; single cycle. inst_type=0 -> BLA, inst_type=1 -> ALPHA.
- BLA: bla_en=1. bla_done=1 -> WAIT_BLA; otherwise stay.
- WAIT_BLA: all outputs 0; single cycle. Always -> FILL.
- FILL: fill_en=1. fill_done=1 -> WAIT_FILL; otherwise stay.
- WAIT_FILL: all outputs 0; single cycle. fifo_empty=0 -> DECODE, else -> IDLE.
- ALPHA: alpha_en=1. alpha_done=1 -> WAIT_ALPHA; otherwise stay.
- WAIT_ALPHA: all outputs 0; single cycle. fifo_empty=0 -> DECODE, else -> IDLE.

Input qualification and timing:
- Each done input is sampled only in its matching active state and ignored elsewhere. A stale or held done therefore cannot skip a state; it is absorbed by the WAIT state.
- config_in is sampled only in IDLE.
- Latency: an enable rises one cycle after the triggering input is sampled.
- A done sampled high in the first cycle of an active state ends that state after exactly 1 cycle.
- read_en is exactly 1 cycle wide per instruction.
- Minimum path per line instruction: DECODE, BLA, WAIT_BLA, FILL, WAIT_FILL = 5 cycles.
- Minimum path per alpha instruction: DECODE, ALPHA, WAIT_ALPHA = 3 cycles.
- Unused or illegal state encodings -> IDLE with all outputs 0.

Test Plan:
- Reset: n_rst=0 asynchronously mid-clock while in BLA -> state IDLE at once; all 5 outputs 0 without waiting for an edge; the FSM stays IDLE after release while config_in=0, even with fifo_empty=0.
- Config path: in IDLE drive config_in=1 for 1 cycle -> config_en=1 next cycle. Hold config_done=0 for 3 cycles -> config_en stays 1. Pulse config_done=1 -> 1 cycle with all outputs 0. With fifo_empty=1 -> IDLE; with fifo_empty=0 -> read_en=1 for exactly 1 cycle.
- Line instruction: DECODE with inst_type=0 -> bla_en=1 until bla_done sampled high. Then 1 idle cycle, then fill_en=1 until fill_done. Then 1 idle cycle, then DECODE if fifo_empty=0, else IDLE.
- Alpha instruction: DECODE with inst_type=1 -> alpha_en=1 for 3 cycles while alpha_done=0. alpha_done=1 -> 1 idle cycle. With fifo_empty=1 -> IDLE and all outputs 0.
- Back-to-back: FIFO holds line then alpha, fifo_empty=0 throughout -> enable sequence read_en, bla_en, 0, fill_en, 0, read_en, alpha_en, 0. No cycle ever has two enables high.
- Stray inputs: pulse bla_done, fill_done and alpha_done while in IDLE and CONFIG, and hold fill_done=1 into the next DECODE -> no state change caused by them; a held done after WAIT_x does not skip the next active state.
